// File: rtl/timer_counter_if.sv
// ---------------------------------------------------------------------------
// timer_counter_if
//
// Word-access bus between the system bridge and one timer_counter window.
// The bridge (master) supplies the decoded word offset, the write strobe and
// the write data. The timer (slave) returns combinational read data and its
// interrupt request.
//
// Signals:
//   addr  [1:0]   word offset in the window (0 CTRL, 1 PRESET, 2 COUNT, 3 none)
//   we            word write strobe, already qualified by window and byte enables
//   din   [31:0]  write data
//   dout  [31:0]  read data for addr, combinational
//   irq           interrupt request toward CP0
// ---------------------------------------------------------------------------
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped 32-bit down-counter timer with one-shot and auto-reload
// modes and a maskable interrupt.
//
// Register map (word offsets):
//   0 CTRL    [0] En, [2:1] Mode (01 auto-reload, others one-shot), [3] IM
//   1 PRESET  32-bit reload value, sampled only when the counter loads
//   2 COUNT   32-bit current count, read-only
//   3 --      reads 0, writes ignored
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    timer_counter_if.slave: addr, we, din in; dout, irq out
// ---------------------------------------------------------------------------
module timer_counter (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic [31:0] w_count_nxt;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_en_clr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic [1:0]  w_mode;

    // Saturating decrement: values of 1 and 0 both land on 0, so the count
    // can never wrap to 0xFFFFFFFF.
    function automatic logic [31:0] f_dec_sat(input logic [31:0] val);
        if (val > 32'd1)
            return val - 32'd1;
        else
            return 32'd0;
    endfunction

    assign w_wr_ctrl   = bus.we && (bus.addr == OFS_CTRL);
    assign w_wr_preset = bus.we && (bus.addr == OFS_PRESET);
    assign w_en        = r_ctrl[0];
    assign w_mode      = r_ctrl[2:1];

    // -----------------------------------------------------------------------
    // Control FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // -----------------------------------------------------------------------
    // Control FSM: next state and datapath requests
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_irq_set   = 1'b0;
        w_irq_clr   = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en) begin
                    // Disabled mid-count: freeze COUNT where it is.
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = f_dec_sat(r_count);
                end else begin
                    w_count_nxt = 32'd0;
                    w_irq_set   = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (w_mode == MODE_AUTO) begin
                    // Auto-reload: single-cycle irq, IDLE then reloads via LOAD.
                    w_irq_clr = 1'b1;
                end else begin
                    // One-shot (and the reserved modes): stop, keep irq_flag.
                    w_en_clr = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // A bus CTRL write takes priority over the FSM clearing En.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ctrl <= 4'd0;
        else if (w_wr_ctrl)
            r_ctrl <= bus.din[3:0];
        else if (w_en_clr)
            r_ctrl[0] <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_preset <= 32'd0;
        else if (w_wr_preset)
            r_preset <= bus.din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= 32'd0;
        else
            r_count <= w_count_nxt;
    end

    // Any CTRL write clears the flag, even in the cycle the FSM would set it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_irq_flag <= 1'b0;
        else if (w_wr_ctrl)
            r_irq_flag <= 1'b0;
        else if (w_irq_set)
            r_irq_flag <= 1'b1;
        else if (w_irq_clr)
            r_irq_flag <= 1'b0;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            OFS_CTRL:   bus.dout = {28'd0, r_ctrl};
            OFS_PRESET: bus.dout = r_preset;
            OFS_COUNT:  bus.dout = r_count;
            default:    bus.dout = 32'd0;
        endcase
    end

    // Built only from registers, so there is no path from din to irq.
    assign bus.irq = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    logic clk;
    logic reset;
    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [1:0] a, input logic w,
                                input logic [31:0] d, input logic [31:0] e,
                                input logic i);
        vec_t v;
        v.addr = a; v.we = w; v.din = d; v.exp_dout = e; v.exp_irq = i;
        vt.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge; sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a; bus.we = 1'b1; bus.din = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.dout, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        // ---------------- vector table ----------------
        // register access from reset (PRESET = 0)
        add(0, 1, 32'hFFFF_FFFF, 32'h0000_000F, 0);
        add(0, 1, 32'h0,         32'h0,         0);
        add(2, 1, 32'h1234_5678, 32'h0,         0);  // COUNT write ignored
        add(3, 1, 32'hFFFF_FFFF, 32'h0,         0);  // offset 3 reads 0
        add(1, 0, 32'h0,         32'h0,         0);
        add(2, 0, 32'h0,         32'h0,         0);
        // mode 00 one-shot, PRESET = 5
        add(1, 1, 32'd5, 32'd5, 0);
        add(0, 1, 32'h9, 32'h9, 0);                  // edge 0
        add(2, 0, 0, 32'd0, 0);                      // edge 1
        for (int k = 5; k >= 1; k--) add(2, 0, 0, k, 0); // edges 2..6
        add(2, 0, 0, 32'd0, 1);                      // edge 7
        add(0, 0, 0, 32'h8, 1);                      // edge 8: En cleared
        add(0, 0, 0, 32'h8, 1);                      // edge 9: irq held
        add(0, 1, 32'h0, 32'h0, 0);                  // CTRL write drops irq
        // mode 01 auto-reload, PRESET = 5
        add(1, 1, 32'd5, 32'd5, 0);
        add(0, 1, 32'hB, 32'hB, 0);                  // edge 0
        add(2, 0, 0, 32'd0, 0);                      // edge 1
        for (int p = 0; p < 3; p++) begin            // irq at 7, 15, 23
            for (int k = 5; k >= 1; k--) add(2, 0, 0, k, 0);
            add(2, 0, 0, 32'd0, 1);
            add(2, 0, 0, 32'd0, 0);
            add(2, 0, 0, 32'd0, 0);
        end
        add(0, 1, 32'h0, 32'h0, 0);                  // stop (state was LOAD)
        add(2, 0, 0, 32'd5, 0);
        add(2, 0, 0, 32'd5, 0);
        // PRESET = 0, mode 01: 4-cycle period
        add(1, 1, 32'd0, 32'd0, 0);
        add(0, 1, 32'hB, 32'hB, 0);                  // edge 0
        add(2, 0, 0, 32'd5, 0);                      // edge 1: old COUNT
        for (int p = 0; p < 3; p++) begin            // irq at 3, 7, 11
            add(2, 0, 0, 32'd0, 0);
            add(2, 0, 0, 32'd0, 1);
            add(2, 0, 0, 32'd0, 0);
            add(2, 0, 0, 32'd0, 0);
        end
        add(0, 1, 32'h0, 32'h0, 0);
        add(2, 0, 0, 32'd0, 0);
        add(2, 0, 0, 32'd0, 0);
        // IM = 0: no irq, En still clears
        add(1, 1, 32'd2, 32'd2, 0);
        add(0, 1, 32'h1, 32'h1, 0);                  // edge 0
        add(2, 0, 0, 32'd0, 0);
        add(2, 0, 0, 32'd2, 0);
        add(2, 0, 0, 32'd1, 0);
        add(2, 0, 0, 32'd0, 0);                      // edge 4: masked
        add(0, 0, 0, 32'h0, 0);                      // edge 5: En cleared
        add(0, 0, 0, 32'h0, 0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        bus.addr = 2'd0; bus.we = 1'b0; bus.din = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            bus.addr = a[1:0];
            #1;
            chk($sformatf("reset_dout%0d", a), bus.dout, 32'd0);
        end
        chk("reset_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table run ----------------
        for (int i = 0; i < vt.size(); i++) begin
            bus.addr = vt[i].addr;
            bus.we   = vt[i].we;
            bus.din  = vt[i].din;
            tick();
            bus.we = 1'b0;
            chk($sformatf("vec%0d_dout", i), bus.dout, vt[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, vt[i].exp_irq});
        end

        // ---------------- freeze / resume, PRESET mid-count ----------------
        wr(1, 32'd10);
        wr(0, 32'h9);                     // edge 0
        repeat (5) tick();                // edges 1..5, COUNT = 7
        wr(0, 32'h8);                     // edge 6: COUNT becomes 6, En off
        rd_chk("freeze_at6", 2, 32'd6);
        repeat (3) tick();
        rd_chk("freeze_hold", 2, 32'd6);
        wr(0, 32'h9);                     // still IDLE at this edge
        rd_chk("resume_idle", 2, 32'd6);
        tick();                           // LOAD
        rd_chk("resume_load", 2, 32'd6);
        tick();
        rd_chk("resume_from_preset", 2, 32'd10);
        wr(1, 32'd3);                     // PRESET change mid-count
        rd_chk("preset_mid_9", 2, 32'd9);
        tick();
        rd_chk("preset_mid_8", 2, 32'd8);
        wr(0, 32'h0);
        rd_chk("stop_7", 2, 32'd7);
        tick();
        rd_chk("stop_hold_7", 2, 32'd7);

        // ---------------- CTRL writes colliding with the FSM ----------------
        wr(0, 32'h9);                     // edge 0, PRESET = 3
        repeat (4) tick();
        rd_chk("int_pre_1", 2, 32'd1);
        tick();                           // edge 5: reaches 0, INT
        chk("int_irq_up", {31'd0, bus.irq}, 32'd1);
        wr(0, 32'h9);                     // write during INT cycle
        rd_chk("int_wr_ctrl", 0, 32'h9);
        chk("int_wr_irq", {31'd0, bus.irq}, 32'd0);
        tick();
        tick();
        rd_chk("int_wr_reload", 2, 32'd3);
        tick();
        tick();
        rd_chk("collide_pre_1", 2, 32'd1);
        wr(0, 32'h8);                     // same edge the FSM sets irq_flag
        chk("collide_irq", {31'd0, bus.irq}, 32'd0);
        rd_chk("collide_ctrl", 0, 32'h8);
        rd_chk("collide_count", 2, 32'd0);
        tick();
        chk("collide_irq_next", {31'd0, bus.irq}, 32'd0);

        // ---------------- asynchronous reset mid-count ----------------
        wr(1, 32'd6);
        wr(0, 32'h9);                     // edge 0
        repeat (5) tick();
        rd_chk("pre_reset_count", 2, 32'd3);
        #1 reset = 1'b1;
        #1 chk("areset_irq", {31'd0, bus.irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.addr = a[1:0];
            #1;
            chk($sformatf("areset_dout%0d", a), bus.dout, 32'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("post_reset_irq%0d", k), {31'd0, bus.irq}, 32'd0);
        end
        rd_chk("post_reset_count", 2, 32'd0);
        rd_chk("post_reset_ctrl", 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counter timer. It sits directly downstream of the data-memory access stage, behind the system bridge. One instance decodes the TC0 window (0x7f00–0x7f0b) and a second decodes the TC1 window (0x7f10–0x7f1b). It receives the already-validated word writes and reads that the memory stage issues, and drives an interrupt request toward the interrupt-pending logic of CP0.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- addr  input  2  word offset within the window, equal to m_data_addr[3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped
- we  input  1  word write strobe; the bridge asserts it when this window is selected and m_data_byteen == 4'b1111
- din  input  32  write data (m_data_wdata)
- dout  output  32  combinational read data for `addr`
- irq  output  1  interrupt request, equal to irq_flag & CTRL[3]

## Operation
Registers:
- CTRL stores only bits [3:0] and reads upper bits as 0.
  - [0] En: enable.
  - [2:1] Mode: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - [3] IM: interrupt mask, 1 = irq allowed.
- PRESET is 32-bit read/write.
- COUNT is 32-bit and read-only. Writes to offset 2 and offset 3 are ignored.
- Reads: offset 0 returns {28'b0, CTRL}, offset 1 returns PRESET, offset 2 returns COUNT, offset 3 returns 0.
- Any write to CTRL clears irq_flag.

FSM states and transitions, evaluated each clock:
- IDLE: if En, go to LOAD; otherwise stay.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If !En, go to IDLE and keep COUNT unchanged (freeze).
  - Else if COUNT > 1, COUNT <= COUNT − 1.
  - Else (COUNT is 1 or 0), COUNT <= 0, irq_flag <= 1, go to INT.
- INT:
  - Mode 00/1x: En <= 0; go to IDLE. irq_flag stays set until a CTRL write or reset.
  - Mode 01: irq_flag <= 0; go to IDLE, which reloads through LOAD on the next cycle.

Rules:
- A bus write to CTRL in the same cycle as an FSM update of En (INT state) wins outright: En takes din[0].
- A bus CTRL write in the same cycle that the FSM sets irq_flag leaves irq_flag = 0.
- A PRESET write takes effect only at the next LOAD. A count in progress is unaffected.
- Decrement is unsigned 32-bit, and COUNT never wraps below 0.

## Timing
- Reset (asynchronous, effective immediately): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0. Therefore irq = 0, and dout = 0 for every addr.
- Reset asserted mid-count aborts the count with no irq pulse.
- Write latency: a register written at edge N is visible on dout after edge N. dout has no read latency and is combinational from addr.
- Count sequence, with the CTRL write setting En at edge 0:
  - Edge 1: IDLE → LOAD.
  - Edge 2: COUNT = P.
  - COUNT reaches 0 and irq rises at edge max(P,1)+2.
- Mode 01 period: max(P,1)+3 cycles between irq rising edges. irq is high for exactly 1 cycle per period.
- Mode 00: irq stays high from edge P+2 until the cycle after a CTRL write. En reads 0 from edge P+3.
- The irq output is registered (irq_flag & CTRL[3]), so it carries no combinational path from din.

## Test plan
- Mode 00 one-shot: PRESET = 5, then CTRL = 0x9 at edge 0 → COUNT reads 5, 4, 3, 2, 1, 0 after edges 2–7; irq rises after edge 7 and stays high; CTRL reads 0x8 after edge 8; writing CTRL = 0 drops irq the next cycle.
- Mode 01 auto-reload: PRESET = 5, CTRL = 0xB → irq is high for one cycle after edges 7, 15 and 23; COUNT reloads to 5 after edge 10.
- Freeze and resume: PRESET = 10, CTRL = 0x9, then write CTRL = 0x8 while COUNT = 6 → COUNT stays 6 and the state stays IDLE; rewriting 0x9 restarts from LOAD (COUNT = 10), not 6.
- Masking and register access:
  - IM = 0 (CTRL = 0x1, PRESET = 2) → irq never asserts, and En clears after the count finishes.
  - Writing 0xFFFFFFFF to CTRL reads back 0xF.
  - Writing to COUNT and to offset 3 changes nothing; offset 3 reads 0.
- Boundary cases:
  - PRESET = 0, mode 01 → irq period of 4 cycles.
  - A PRESET write mid-count does not alter the current COUNT.
  - A CTRL write in the INT cycle in mode 00 → En equals the written bit.
- Asynchronous reset asserted between clock edges while COUNT = 3 → all registers, dout and irq are 0 immediately; after release the block stays in IDLE with no irq.
